music_player_ctrl: RTL and testbench
====================================

Name: music_player_ctrl

Overview:
- Sequencing controller for the music player datapath.
- Converts single-cycle, already-debounced button pulses (play, next, rewind, fast-forward) into control signals for the song reader and note player:
  - run enable
  - song select
  - playback direction
  - double-speed
  - a timed flush/reset of the player pipeline
- Sits between the button debouncers and the song_reader/note_player chain.
- Consumes the beat tick and the song-boundary status coming back from that chain.

Parameters:
- NUM_SONGS, 4, number of songs in ROM; song index wraps modulo NUM_SONGS
- SONG_W, 2, width of song index (>= clog2(NUM_SONGS))
- FLUSH_CYCLES, 16, cycles player_reset is held high on song change (1..255)
- SEEK_BEATS, 8, beats a fast-forward burst lasts before returning to normal play (1..255)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- play_button  input  1  one-cycle pulse; toggle play/pause
- next_button  input  1  one-cycle pulse; advance to next song
- rewind_button  input  1  one-cycle pulse; enter reverse playback
- ff_button  input  1  one-cycle pulse; enter double-speed burst
- beat  input  1  one-cycle pulse per beat from beat generator
- song_done  input  1  reader has passed last note (forward direction)
- song_start  input  1  reader is at first note of song
- play  output  1  run enable to song_reader/note_player
- song  output  SONG_W  current song index
- reverse  output  1  reader steps addresses downward
- speed_x2  output  1  reader consumes two notes per beat
- player_reset  output  1  synchronous clear to reader/player pipeline
- state_dbg  output  3  encoded FSM state for bench/LEDs

Behaviour:
- All outputs are registered. Reset values: play=0, song=0, reverse=0, speed_x2=0, player_reset=0, state=PAUSED (state_dbg=0).
- Reset is asynchronous: outputs are forced to reset values immediately, regardless of clk. Mid-operation reset abandons any flush or seek; no residual counts remain.
- States, with state_dbg encoding:
  - PAUSED=0
  - PLAYING=1
  - FLUSH=2
  - SEEK_FWD=3
  - SEEK_REV=4
- Button priority when multiple pulses arrive in the same cycle: next > play > rewind > ff. Lower-priority pulses are dropped, not queued.
- PAUSED:
  - play_button -> PLAYING.
  - next_button -> FLUSH with song+1; returns to PAUSED afterward.
  - rewind/ff ignored.
- PLAYING:
  - play_button -> PAUSED.
  - next_button -> FLUSH; returns to PLAYING.
  - rewind_button -> SEEK_REV.
  - ff_button -> SEEK_FWD, with beat counter loaded to SEEK_BEATS.
  - song_done -> end-of-song handling (see Optional Feature).
- FLUSH:
  - player_reset=1 and play=0 for exactly FLUSH_CYCLES cycles.
  - song updates on the entry cycle.
  - Then goes to the recorded return state (PAUSED or PLAYING).
  - Buttons are ignored except next_button, which increments song again and restarts the flush count.
- SEEK_FWD:
  - play=1, speed_x2=1.
  - Counter decrements on each beat; at 0 -> PLAYING.
  - song_done -> end-of-song handling as in PLAYING.
  - ff_button reloads the counter.
  - play_button -> PAUSED, clearing speed_x2.
  - rewind_button -> SEEK_REV.
- SEEK_REV:
  - play=1, reverse=1.
  - song_start -> PLAYING, reverse cleared next cycle.
  - rewind_button or ff_button -> PLAYING.
  - play_button -> PAUSED.
- next_button in any SEEK state -> FLUSH with return to PLAYING; reverse and speed_x2 are cleared.
- Song increments wrap: NUM_SONGS-1 -> 0.
- beat is ignored outside SEEK_FWD.
- reverse and speed_x2 are never 1 simultaneously.

Optional Feature:
- Macro AUTO_ADVANCE_EN.
- When defined: song_done in PLAYING/SEEK_FWD -> FLUSH with song+1, returning to PLAYING (continuous playlist).
- When undefined: song_done -> FLUSH with the same song, returning to PAUSED (song rewinds to its start and stops).

Test Plan:
- Reset low then high; play pulse -> play=1 next cycle, state_dbg=1; second play pulse -> play=0, state_dbg=0.
- PAUSED, song=3, NUM_SONGS=4; next pulse -> song=0, player_reset high exactly 16 cycles, play=0 throughout, then state_dbg=0.
- PLAYING; ff pulse -> speed_x2=1; after 8 beat pulses speed_x2=0 and state_dbg=1; an ff pulse at beat 5 extends the burst to 13 beats total.
- PLAYING; rewind pulse -> reverse=1; assert song_start -> reverse=0, state_dbg=1; same-cycle next+play+ff -> only next acts (FLUSH, song+1).
- song_done in PLAYING with song=1:
  - AUTO_ADVANCE_EN defined -> song=2, play=1 after flush.
  - AUTO_ADVANCE_EN undefined -> song=1, play=0 after flush.
- Assert reset low mid-FLUSH (cycle 5) and mid-SEEK_FWD -> all outputs 0 asynchronously; after release, play pulse behaves as from a fresh reset.

Source files
------------

// File: rtl/music_player_ctrl.sv
// music_player_ctrl: turns debounced button pulses into run/song/direction/speed/flush
// controls for the song_reader/note_player chain.
// Optional feature macro: AUTO_ADVANCE_EN. When it is defined, the end of a song moves on
// to the next song. When it is not defined, the same song rewinds to its start and pauses.
module music_player_ctrl #(
  parameter int unsigned NUM_SONGS    = 4,
  parameter int unsigned SONG_W       = 2,
  parameter int unsigned FLUSH_CYCLES = 16,
  parameter int unsigned SEEK_BEATS   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              rewind_button,
  input  logic              ff_button,
  input  logic              beat,
  input  logic              song_done,
  input  logic              song_start,
  output logic              play,
  output logic [SONG_W-1:0] song,
  output logic              reverse,
  output logic              speed_x2,
  output logic              player_reset,
  output logic [2:0]        state_dbg
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STATE_W = 3;
  // The flush counter runs from FLUSH_CYCLES-1 down to 0, which gives exactly FLUSH_CYCLES cycles.
  localparam logic [CNT_W-1:0]  FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SEEK_LOAD  = CNT_W'(SEEK_BEATS);
  localparam logic [SONG_W-1:0] LAST_SONG  = SONG_W'(NUM_SONGS - 1);

  typedef enum logic [STATE_W-1:0] {
    PAUSED   = 3'd0,
    PLAYING  = 3'd1,
    FLUSH    = 3'd2,
    SEEK_FWD = 3'd3,
    SEEK_REV = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              ret_play_q, ret_play_d;
  logic [SONG_W-1:0] song_q, song_d, song_inc;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  seek_cnt_q, seek_cnt_d;
  logic              flush_go, flush_adv, flush_ret_play;
  logic              eos_adv, eos_ret_play;

  assign song_inc = (song_q == LAST_SONG) ? '0 : song_q + SONG_W'(1);

  // End-of-song policy: either advance and keep playing, or rewind the same song and stop.
`ifdef AUTO_ADVANCE_EN
  assign eos_adv      = 1'b1;
  assign eos_ret_play = 1'b1;
`else
  assign eos_adv      = 1'b0;
  assign eos_ret_play = 1'b0;
`endif

  // Next-state logic. Buttons take priority as next > play > rewind > ff, and status inputs come after the buttons.
  always_comb begin
    state_d        = state_q;
    ret_play_d     = ret_play_q;
    song_d         = song_q;
    flush_cnt_d    = flush_cnt_q;
    seek_cnt_d     = seek_cnt_q;
    flush_go       = 1'b0;
    flush_adv      = 1'b0;
    flush_ret_play = 1'b0;

    case (state_q)
      PAUSED: begin
        if (next_button) begin
          flush_go  = 1'b1;
          flush_adv = 1'b1;
        end else if (play_button) begin
          state_d = PLAYING;
        end
      end
      PLAYING: begin
        if (next_button) begin
          flush_go       = 1'b1;
          flush_adv      = 1'b1;
          flush_ret_play = 1'b1;
        end else if (play_button) begin
          state_d = PAUSED;
        end else if (rewind_button) begin
          state_d = SEEK_REV;
        end else if (ff_button) begin
          state_d    = SEEK_FWD;
          seek_cnt_d = SEEK_LOAD;
        end else if (song_done) begin
          flush_go       = 1'b1;
          flush_adv      = eos_adv;
          flush_ret_play = eos_ret_play;
        end
      end
      FLUSH: begin
        if (next_button) begin
          song_d      = song_inc;
          flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q == '0) begin
          state_d = ret_play_q ? PLAYING : PAUSED;
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_W'(1);
        end
      end
      SEEK_FWD: begin
        if (next_button) begin
          flush_go       = 1'b1;
          flush_adv      = 1'b1;
          flush_ret_play = 1'b1;
        end else if (play_button) begin
          state_d = PAUSED;
        end else if (rewind_button) begin
          state_d = SEEK_REV;
        end else if (ff_button) begin
          seek_cnt_d = SEEK_LOAD;
        end else if (song_done) begin
          flush_go       = 1'b1;
          flush_adv      = eos_adv;
          flush_ret_play = eos_ret_play;
        end else if (beat) begin
          if (seek_cnt_q <= CNT_W'(1)) begin
            state_d    = PLAYING;
            seek_cnt_d = '0;
          end else begin
            seek_cnt_d = seek_cnt_q - CNT_W'(1);
          end
        end
      end
      SEEK_REV: begin
        if (next_button) begin
          flush_go       = 1'b1;
          flush_adv      = 1'b1;
          flush_ret_play = 1'b1;
        end else if (play_button) begin
          state_d = PAUSED;
        end else if (rewind_button || ff_button || song_start) begin
          state_d = PLAYING;
        end
      end
      default: state_d = PAUSED;
    endcase

    if (flush_go) begin
      state_d     = FLUSH;
      ret_play_d  = flush_ret_play;
      flush_cnt_d = FLUSH_LOAD;
      seek_cnt_d  = '0;
      if (flush_adv) song_d = song_inc;
    end
  end

  // State and counter registers, with outputs decoded from the next state so that they are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= PAUSED;
      ret_play_q   <= 1'b0;
      song_q       <= '0;
      flush_cnt_q  <= '0;
      seek_cnt_q   <= '0;
      play         <= 1'b0;
      song         <= '0;
      reverse      <= 1'b0;
      speed_x2     <= 1'b0;
      player_reset <= 1'b0;
      state_dbg    <= '0;
    end else begin
      state_q      <= state_d;
      ret_play_q   <= ret_play_d;
      song_q       <= song_d;
      flush_cnt_q  <= flush_cnt_d;
      seek_cnt_q   <= seek_cnt_d;
      play         <= (state_d == PLAYING) || (state_d == SEEK_FWD) || (state_d == SEEK_REV);
      song         <= song_d;
      reverse      <= (state_d == SEEK_REV);
      speed_x2     <= (state_d == SEEK_FWD);
      player_reset <= (state_d == FLUSH);
      state_dbg    <= STATE_W'(state_d);
    end
  end

endmodule

// File: tb/tb_music_player_ctrl.sv
// Scoreboard bench for music_player_ctrl: the driver steps a reference model and queues
// the expected output, and the monitor checks the DUT outputs after every clock edge.
module tb_music_player_ctrl;

  localparam int NUM_SONGS    = 4;
  localparam int SONG_W       = 2;
  localparam int FLUSH_CYCLES = 16;
  localparam int SEEK_BEATS   = 8;

  localparam int M_PAUSED = 0, M_PLAYING = 1, M_FLUSH = 2, M_SEEK_FWD = 3, M_SEEK_REV = 4;

  typedef struct packed {
    logic              play;
    logic [SONG_W-1:0] song;
    logic              reverse;
    logic              speed_x2;
    logic              player_reset;
    logic [2:0]        st;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic play_button = 1'b0, next_button = 1'b0, rewind_button = 1'b0, ff_button = 1'b0;
  logic beat = 1'b0, song_done = 1'b0, song_start = 1'b0;
  logic play, reverse, speed_x2, player_reset;
  logic [SONG_W-1:0] song;
  logic [2:0] state_dbg;
  obs_t dut_obs;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   run = 1'b0;

  // Reference model: the playback mode, song number, flush cycles still to run and seek beats still to run.
  int m_mode, m_song, m_ret, m_fl, m_sb;

  music_player_ctrl #(
    .NUM_SONGS(NUM_SONGS), .SONG_W(SONG_W), .FLUSH_CYCLES(FLUSH_CYCLES), .SEEK_BEATS(SEEK_BEATS)
  ) dut (
    .clk(clk), .reset(reset),
    .play_button(play_button), .next_button(next_button),
    .rewind_button(rewind_button), .ff_button(ff_button),
    .beat(beat), .song_done(song_done), .song_start(song_start),
    .play(play), .song(song), .reverse(reverse), .speed_x2(speed_x2),
    .player_reset(player_reset), .state_dbg(state_dbg)
  );

  assign dut_obs = {play, song, reverse, speed_x2, player_reset, state_dbg};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  function automatic obs_t model_obs();
    obs_t o;
    o.play         = (m_mode == M_PLAYING || m_mode == M_SEEK_FWD || m_mode == M_SEEK_REV);
    o.song         = SONG_W'(m_song);
    o.reverse      = (m_mode == M_SEEK_REV);
    o.speed_x2     = (m_mode == M_SEEK_FWD);
    o.player_reset = (m_mode == M_FLUSH);
    o.st           = 3'(m_mode);
    return o;
  endfunction

  task automatic model_reset();
    m_mode = M_PAUSED; m_song = 0; m_ret = M_PAUSED; m_fl = 0; m_sb = 0;
  endtask

  task automatic start_flush(input bit adv, input int ret);
    if (adv) m_song = (m_song + 1) % NUM_SONGS;
    m_fl = FLUSH_CYCLES;
    m_ret = ret;
    m_mode = M_FLUSH;
  endtask

  task automatic end_of_song();
`ifdef AUTO_ADVANCE_EN
    start_flush(1'b1, M_PLAYING);
`else
    start_flush(1'b0, M_PAUSED);
`endif
  endtask

  task automatic model_step(input bit nx, pl, rw, ff, bt, sd, ss);
    case (m_mode)
      M_PAUSED:
        if (nx) start_flush(1'b1, M_PAUSED);
        else if (pl) m_mode = M_PLAYING;
      M_PLAYING:
        if (nx) start_flush(1'b1, M_PLAYING);
        else if (pl) m_mode = M_PAUSED;
        else if (rw) m_mode = M_SEEK_REV;
        else if (ff) begin m_mode = M_SEEK_FWD; m_sb = SEEK_BEATS; end
        else if (sd) end_of_song();
      M_FLUSH:
        if (nx) begin m_song = (m_song + 1) % NUM_SONGS; m_fl = FLUSH_CYCLES; end
        else begin
          m_fl = m_fl - 1;
          if (m_fl == 0) m_mode = m_ret;
        end
      M_SEEK_FWD:
        if (nx) start_flush(1'b1, M_PLAYING);
        else if (pl) m_mode = M_PAUSED;
        else if (rw) m_mode = M_SEEK_REV;
        else if (ff) m_sb = SEEK_BEATS;
        else if (sd) end_of_song();
        else if (bt) begin
          m_sb = m_sb - 1;
          if (m_sb == 0) m_mode = M_PLAYING;
        end
      M_SEEK_REV:
        if (nx) start_flush(1'b1, M_PLAYING);
        else if (pl) m_mode = M_PAUSED;
        else if (rw || ff || ss) m_mode = M_PLAYING;
      default: m_mode = M_PAUSED;
    endcase
  endtask

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got play=%b song=%0d rev=%b x2=%b prst=%b st=%0d, expected play=%b song=%0d rev=%b x2=%b prst=%b st=%0d",
               name, $time, got.play, got.song, got.reverse, got.speed_x2, got.player_reset, got.st,
               exp.play, exp.song, exp.reverse, exp.speed_x2, exp.player_reset, exp.st);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected outputs for the next rising edge.
  task automatic cycle(input bit nx, pl, rw, ff, bt, sd, ss);
    @(negedge clk);
    next_button = nx; play_button = pl; rewind_button = rw; ff_button = ff;
    beat = bt; song_done = sd; song_start = ss;
    model_step(nx, pl, rw, ff, bt, sd, ss);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Pull reset low between clock edges and check that the outputs clear without waiting for a clock edge.
  task automatic async_reset();
    obs_t zero;
    zero = '0;
    @(negedge clk);
    next_button = 0; play_button = 0; rewind_button = 0; ff_button = 0;
    beat = 0; song_done = 0; song_start = 0;
    #2 reset = 1'b0;
    #1 check("async_reset", dut_obs, zero);
    model_reset();
    exp_q.push_back(model_obs());
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(model_obs());
  endtask

  // Monitor: after each rising edge, take the oldest expected value from the queue and compare it with the DUT.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (run) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard_underflow @%0t: got empty queue, expected an entry", $time);
        end else begin
          e = exp_q.pop_front();
          check("outputs", dut_obs, e);
        end
      end
    end
  end

  initial begin
    obs_t zero;
    int r;
    bit nx, pl, rw, ff, bt, sd, ss;
    zero = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_values", dut_obs, zero);
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(model_obs());
    run = 1'b1;

    // play toggles between PLAYING and PAUSED
    cycle(0, 1, 0, 0, 0, 0, 0); idle(2);
    cycle(0, 1, 0, 0, 0, 0, 0); idle(2);
    // step to song 3 while paused, then wrap to 0 and flush for the full count
    for (int k = 0; k < 4; k++) begin cycle(1, 0, 0, 0, 0, 0, 0); idle(20); end
    cycle(1, 0, 0, 0, 0, 0, 0); idle(20);
    // play, then an ff burst that is reloaded after the 5th beat (13 beats in total)
    cycle(0, 1, 0, 0, 0, 0, 0); idle(1);
    cycle(0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin cycle(0, 0, 0, 0, 1, 0, 0); idle(1); end
    cycle(0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin cycle(0, 0, 0, 0, 1, 0, 0); idle(1); end
    idle(2);
    // rewind, leave it on song_start, rewind again, then next+play+ff in the same cycle
    cycle(0, 0, 1, 0, 0, 0, 0); idle(3);
    cycle(0, 0, 0, 0, 0, 0, 1); idle(2);
    cycle(0, 0, 1, 0, 0, 0, 0); idle(2);
    cycle(1, 1, 0, 1, 0, 0, 0); idle(20);
    // move to song 1 while playing, then end of song
    for (int k = 0; k < 3; k++) begin cycle(1, 0, 0, 0, 0, 0, 0); idle(20); end
    cycle(0, 0, 0, 0, 0, 1, 0); idle(20);
    // reset in the middle of a flush
    cycle(1, 0, 0, 0, 0, 0, 0); idle(4);
    async_reset();
    cycle(0, 1, 0, 0, 0, 0, 0); idle(2);
    // reset in the middle of a fast-forward burst
    cycle(0, 0, 0, 1, 0, 0, 0); cycle(0, 0, 0, 0, 1, 0, 0); idle(1);
    async_reset();
    cycle(0, 1, 0, 0, 0, 0, 0); idle(2);

    // random traffic: buttons (possibly several in one cycle) or a single status event
    for (int k = 0; k < 3000; k++) begin
      if (k == 1111 || k == 2222) async_reset();
      nx = ($urandom_range(0, 99) < 3);
      pl = ($urandom_range(0, 99) < 5);
      rw = ($urandom_range(0, 99) < 5);
      ff = ($urandom_range(0, 99) < 5);
      bt = 0; sd = 0; ss = 0;
      if (!(nx || pl || rw || ff)) begin
        r = int'($urandom_range(0, 99));
        if (r < 30) bt = 1;
        else if (r < 33) sd = 1;
        else if (r < 38) ss = 1;
      end
      cycle(nx, pl, rw, ff, bt, sd, ss);
    end
    idle(20);

    @(posedge clk);
    #3;
    run = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
